// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-port load/store controller between a RISC-V style request
// port and a word-wide RAM with a combinational read path.
// Loads take READ then RESP; SW goes straight to WRITE; SB/SH do a
// read-modify-write (READ, WRITE, RESP); bad requests go directly to RESP.
// Optional feature macro: LSU_ALIGN_CHECK_EN (reject misaligned half/word
// accesses instead of aligning them down).
module lsu_ctrl #(
    parameter int RAM_AW = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    // The word index ram_addr[RAM_AW+1:2] must fit inside a 32-bit address.
    if (RAM_AW < 1 || RAM_AW > 30) begin : g_aw_range
        $error("lsu_ctrl: RAM_AW must be in 1..30");
    end

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;      // only SB/SH need the latched data; SW writes req_wdata directly
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        ram_en_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;

    logic        req_bad_d;
    logic [31:0] rd_ext_d;
    logic [31:0] merged_d;

    // Funct3 codes outside the supported load/store widths.
    function automatic logic bad_funct3(input logic we, input logic [2:0] f3);
        if (we) return f3[2] | (f3[1:0] == 2'b11);
        return (f3[1:0] == 2'b11) | (f3 == 3'b110);
    endfunction

    // Select byte/half from the read word and sign- or zero-extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte or half of the old word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (f3[1:0] == 2'b00) begin
            r[{a, 3'b000} +: 8] = wd[7:0];
        end else if (a[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        return r;
    endfunction

    // Request classification and datapath results for the current state.
    always_comb begin
        req_bad_d = bad_funct3(req_we, req_funct3);
`ifdef LSU_ALIGN_CHECK_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            req_bad_d = 1'b1;
`endif
        rd_ext_d = load_ext(ram_rdata, f3_q, addr_q[1:0]);
        merged_d = merge(ram_rdata, wdata_q, f3_q, addr_q[1:0]);
    end

    // Controller FSM with registered RAM and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata[15:0];
                        if (req_bad_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            state_q     <= WRITE;
                            ram_en_q    <= 1'b1;
                            ram_addr_q  <= {req_addr[31:2], 2'b00};
                            ram_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= READ;
                            ram_addr_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state_q     <= WRITE;
                        ram_en_q    <= 1'b1;
                        ram_addr_q  <= {addr_q[31:2], 2'b00};
                        ram_wdata_q <= merged_d;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rd_ext_d;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset masks the outputs within the reset cycle itself, so an
    // in-flight WRITE is suppressed immediately.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q & ~rst;
    assign resp_err   = resp_err_q & ~rst;
    assign resp_rdata = rst ? '0 : resp_rdata_q;
    assign ram_en     = ram_en_q & ~rst;
    assign ram_addr   = rst ? '0 : ram_addr_q;
    assign ram_wdata  = rst ? '0 : ram_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 14: word-index width; the word index is ram_addr[RAM_AW+1:2] and higher address bits are ignored (the index wraps).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: memory request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both high.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RISC-V width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: load result, extended to 32 bits.
REQ-012 SHALL have port resp_err, output, 1: request rejected, qualified by resp_valid.
REQ-013 SHALL have port ram_en, output, 1: word write enable to the RAM.
REQ-014 SHALL have port ram_addr, output, 32: byte address to the RAM, bits [1:0] always 0.
REQ-015 SHALL have port ram_wdata, output, 32: word written to the RAM.
REQ-016 SHALL have port ram_rdata, input, 32: RAM read word, combinational from ram_addr.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = (state==IDLE) and not rst.
REQ-018 SHALL latch req_we, req_funct3, req_addr and req_wdata on acceptance and hold them unchanged until returning to IDLE.
REQ-019 SHALL drive ram_addr = {latched addr[31:2], 2'b00} in READ and WRITE states, and 0 in all other states.
REQ-020 Load timing: accept at cycle N; READ at N+1 captures ram_rdata; RESP at N+2 with resp_valid=1.
REQ-021 Load extension: LB/LH sign-extend, LBU/LHU zero-extend; the byte is selected by addr[1:0] and the half by addr[1].
REQ-022 SW timing: accept at N; WRITE at N+1 with ram_en=1 and ram_wdata=req_wdata; RESP at N+2.
REQ-023 SB/SH timing (read-modify-write): READ at N+1 captures the old word; WRITE at N+2 writes the merged word (only the addressed byte or half is replaced); RESP at N+3.
REQ-024 ram_en SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-025 An invalid funct3 (loads 011/110/111; stores 011 and above) SHALL go IDLE->RESP at N+1 with resp_err=1, resp_rdata=0 and no RAM write.
REQ-026 resp_rdata SHALL be 0 when resp_valid=0, and 0 for stores; after RESP the FSM SHALL always return to IDLE.
REQ-027 Back-to-back requests SHALL be accepted at the earliest in the cycle after RESP; there is no overlap.

Reset
REQ-028 rst=1 SHALL force state=IDLE and resp_valid, resp_err, resp_rdata, ram_en, ram_addr and ram_wdata to 0, and req_ready to 0 during the reset cycle.
REQ-029 rst asserted mid-operation (including in WRITE) SHALL abort the request with no RAM write in that cycle and no response; req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With LSU_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL take the REQ-025 error path at N+1 with no RAM write.
REQ-031 Without LSU_ALIGN_CHECK_EN: misaligned accesses SHALL be aligned down (LW/SW ignore addr[1:0]; halfword accesses ignore addr[0]); resp_err SHALL flag only invalid funct3.

Verification
REQ-032 SW at 0x10 with data 0xDEADBEEF, then LW at 0x10 -> ram_en pulses once with ram_addr=0x10; the load returns resp_rdata=0xDEADBEEF at N+2.
REQ-033 Word at 0x20 = 0x11223344; SB of 0xAA at 0x22 -> the written word is 0x11AA3344, resp_valid at N+3; LBU at 0x22 -> 0x000000AA; LB at 0x22 -> 0xFFFFFFAA.
REQ-034 Word at 0x20 = 0x8001_7FFF; LH at 0x22 -> 0xFFFF8001; LHU at 0x20 -> 0x00007FFF.
REQ-035 LW at 0x13 -> with LSU_ALIGN_CHECK_EN: resp_err=1 at N+1 and no ram_en; without it: returns the word at 0x10 with resp_err=0.
REQ-036 rst asserted during the READ cycle of an SB to 0x40 -> the word at 0x40 is unchanged, no resp_valid, and req_ready=1 in the first cycle after reset; req_valid held high continuously -> exactly one acceptance per completed response.
